// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: default width and
// the FSM state encoding.
package serial_add_ctrl_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/fullAdder.sv
// One-bit full-adder cell, reused by the serial adder for every bit position.
module fullAdder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic carry
);

  // Pure combinational sum/carry of three input bits.
  always_comb begin
    sum   = a ^ b ^ c_in;
    carry = (a & b) | (c_in & (a ^ b));
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: accepts two WIDTH-bit operands plus carry-in,
// feeds one bit per clock (LSB first) through a single full-adder cell and
// presents {c_out, sum} on a valid/ready response channel.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   sum_sh_q, sum_sh_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               fa_sum;
  logic               fa_carry;
  logic               accept;

  // The shared arithmetic cell always looks at the current LSBs and carry.
  fullAdder u_fa (
    .a     (a_sh_q[0]),
    .b     (b_sh_q[0]),
    .c_in  (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // Handshake and status outputs decoded straight from the state register.
  always_comb begin
    start_ready  = (state_q == ST_IDLE);
    result_valid = (state_q == ST_DONE);
    busy         = (state_q != ST_IDLE);
    accept       = start_valid && start_ready;
    sum          = sum_sh_q;
    c_out        = carry_q;
  end

  // Next-state and datapath update for load, shift and hold.
  always_comb begin
    // NOTE: every signal gets a hold default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = c_in;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        sum_sh_d = {fa_sum, sum_sh_q[WIDTH-1:1]};
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        carry_d  = fa_carry;
        // Counter parks on the last index instead of wrapping.
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        if (result_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: async reset clears every register, including the shift registers, so sum reads 0 at once.
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
